// File: rtl/mips_main_fsm.sv
// Main control FSM of the multicycle MIPS core: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath select and write enable.
module mips_main_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_t;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;
  logic   ready;

  // With waiting disabled the memory is assumed single-cycle.
  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks below use blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    ctrl       = '0;
    state_next = S_FETCH;
    unique case (state)
      S_FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
        state_next     = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_next      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        if (op == OP_LW)      state_next = S_MEMREAD;
        else if (op == OP_SW) state_next = S_MEMWRITE;
        else                  state_next = S_FETCH;
      end
      S_MEMREAD: begin
        ctrl.iord  = 1'b1;
        state_next = ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        // Write request stays up until memory accepts it.
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        state_next     = ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
        state_next     = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_next     = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: begin
        ctrl.pc_src = PC_ALU;
      end
    endcase
  end

  // Reset overrides everything so an aborted instruction never commits.
  assign ctrl_out = reset ? '0 : ctrl;

  assign pc_write   = ctrl_out.pc_write;
  assign branch     = ctrl_out.branch;
  assign iord       = ctrl_out.iord;
  assign mem_write  = ctrl_out.mem_write;
  assign ir_write   = ctrl_out.ir_write;
  assign reg_dst    = ctrl_out.reg_dst;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign reg_write  = ctrl_out.reg_write;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign alu_op     = ctrl_out.alu_op;
  assign pc_src     = ctrl_out.pc_src;
  assign illegal_op = ctrl_out.illegal_op;
  assign state_o    = reset ? 4'd0 : state;

endmodule

// File: tb/tb_mips_main_fsm.sv
// Directed bench for mips_main_fsm: per-cycle vector table plus hand-written
// multi-cycle sequences for memory stalls, and a second instance with waiting disabled.
module tb_mips_main_fsm;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  // Control word order: pc_write branch iord mem_write ir_write reg_dst mem_to_reg
  // reg_write alu_src_a alu_src_b[1:0] alu_op[1:0] pc_src[1:0] illegal_op
  localparam logic [15:0] K_ZERO   = 16'b0;
  localparam logic [15:0] K_FETCH  = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [15:0] K_FWAIT  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [15:0] K_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [15:0] K_ILLEG  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
  localparam logic [15:0] K_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [15:0] K_MEMRD  = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [15:0] K_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [15:0] K_MEMWR  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [15:0] K_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam logic [15:0] K_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [15:0] K_BRANCH = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [15:0] K_ADDIEX = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [15:0] K_ADDIWB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [15:0] K_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  exp_state;
    logic [15:0] exp_ctrl;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'b0;
  logic       mem_ready = 1'b1;

  logic       pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_o;

  logic       n_pc_write, n_branch, n_iord, n_mem_write, n_ir_write, n_reg_dst, n_mem_to_reg;
  logic       n_reg_write, n_alu_src_a, n_illegal_op;
  logic [1:0] n_alu_src_b, n_alu_op, n_pc_src;
  logic [3:0] n_state_o;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mips_main_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op), .state_o(state_o)
  );

  mips_main_fsm #(.MEM_WAIT_EN(1'b0)) dut_nowait (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_write(n_pc_write), .branch(n_branch), .iord(n_iord), .mem_write(n_mem_write),
    .ir_write(n_ir_write), .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg),
    .reg_write(n_reg_write), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
    .alu_op(n_alu_op), .pc_src(n_pc_src), .illegal_op(n_illegal_op), .state_o(n_state_o)
  );

  logic [15:0] ctrl_act;
  assign ctrl_act = {pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] o, input logic m,
                     input logic [3:0] s, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.op = o; v.rdy = m; v.exp_state = s; v.exp_ctrl = c;
    vecs.push_back(v);
  endtask

  // Leaves reset high; the next driven cycle releases it with the machine in FETCH.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
  endtask

  // lw with k stall cycles in FETCH and k in MEMREAD; returns cycles FETCH..MEMWB.
  task automatic run_lw(input int k, output int cycles, output bit done);
    int fs = 0;
    int ms = 0;
    bit seen_decode = 1'b0;
    cycles = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      reset = 1'b0;
      op = LW;
      if (state_o == 4'd0 && fs < k) begin mem_ready = 1'b0; fs++; end
      else if (state_o == 4'd3 && ms < k) begin mem_ready = 1'b0; ms++; end
      else mem_ready = 1'b1;
      cycles++;
      @(posedge clk);
      #1;
      if (state_o == 4'd1) seen_decode = 1'b1;
      if (state_o == 4'd0 && seen_decode) done = 1'b1;
    end
  endtask

  initial begin
    int  cycles;
    bit  done;
    int  mw_cnt, mw_run, mw_max, overlap, stalls;
    bit  seen_decode;

    // Reset held three cycles with an unknown opcode.
    repeat (3) add(1'b1, 6'bxxxxxx, 1'b1, 4'd0, K_ZERO);
    // lw, no stalls
    add(1'b0, LW, 1'b1, 4'd0, K_FETCH);
    add(1'b0, LW, 1'b1, 4'd1, K_DECODE);
    add(1'b0, LW, 1'b1, 4'd2, K_MEMADR);
    add(1'b0, LW, 1'b1, 4'd3, K_MEMRD);
    add(1'b0, LW, 1'b1, 4'd4, K_MEMWB);
    // sw with two stalled MEMWRITE cycles
    add(1'b0, SW, 1'b1, 4'd0, K_FETCH);
    add(1'b0, SW, 1'b1, 4'd1, K_DECODE);
    add(1'b0, SW, 1'b1, 4'd2, K_MEMADR);
    add(1'b0, SW, 1'b0, 4'd5, K_MEMWR);
    add(1'b0, SW, 1'b0, 4'd5, K_MEMWR);
    add(1'b0, SW, 1'b1, 4'd5, K_MEMWR);
    // R-type, beq, j back to back
    add(1'b0, RT, 1'b1, 4'd0, K_FETCH);
    add(1'b0, RT, 1'b1, 4'd1, K_DECODE);
    add(1'b0, RT, 1'b1, 4'd6, K_EXEC);
    add(1'b0, RT, 1'b1, 4'd7, K_ALUWB);
    add(1'b0, BEQ, 1'b1, 4'd0, K_FETCH);
    add(1'b0, BEQ, 1'b1, 4'd1, K_DECODE);
    add(1'b0, BEQ, 1'b1, 4'd8, K_BRANCH);
    add(1'b0, JMP, 1'b1, 4'd0, K_FETCH);
    add(1'b0, JMP, 1'b1, 4'd1, K_DECODE);
    add(1'b0, JMP, 1'b1, 4'd11, K_JUMP);
    // addi
    add(1'b0, ADDI, 1'b1, 4'd0, K_FETCH);
    add(1'b0, ADDI, 1'b1, 4'd1, K_DECODE);
    add(1'b0, ADDI, 1'b1, 4'd9, K_ADDIEX);
    add(1'b0, ADDI, 1'b1, 4'd10, K_ADDIWB);
    // illegal opcode pulses once then back to FETCH
    add(1'b0, BAD, 1'b1, 4'd0, K_FETCH);
    add(1'b0, BAD, 1'b1, 4'd1, K_ILLEG);
    // FETCH stall: two waiting cycles
    add(1'b0, LW, 1'b0, 4'd0, K_FWAIT);
    add(1'b0, LW, 1'b0, 4'd0, K_FWAIT);
    add(1'b0, LW, 1'b1, 4'd0, K_FETCH);
    add(1'b0, LW, 1'b1, 4'd1, K_DECODE);
    add(1'b0, LW, 1'b1, 4'd2, K_MEMADR);
    add(1'b0, LW, 1'b0, 4'd3, K_MEMRD);
    // reset during stalled MEMREAD aborts without writeback
    add(1'b1, LW, 1'b0, 4'd0, K_ZERO);
    add(1'b0, LW, 1'b1, 4'd0, K_FETCH);
    add(1'b0, LW, 1'b1, 4'd1, K_DECODE);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      op = vecs[i].op;
      mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl_act), 32'(vecs[i].exp_ctrl));
    end

    // Each stall cycle in FETCH or MEMREAD adds exactly one cycle to lw.
    for (int k = 0; k < 3; k++) begin
      do_reset();
      run_lw(k, cycles, done);
      check($sformatf("lw_stall%0d_done", k), 32'(done), 32'd1);
      check($sformatf("lw_stall%0d_cycles", k), 32'(cycles), 32'(5 + 2 * k));
    end

    // sw: mem_write held across two stall cycles, never alongside ir_write.
    do_reset();
    mw_cnt = 0; mw_run = 0; mw_max = 0; overlap = 0; stalls = 0;
    seen_decode = 1'b0; done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      reset = 1'b0;
      op = SW;
      if (state_o == 4'd5 && stalls < 2) begin mem_ready = 1'b0; stalls++; end
      else mem_ready = 1'b1;
      #1;
      if (mem_write) begin mw_cnt++; mw_run++; end
      else mw_run = 0;
      if (mw_run > mw_max) mw_max = mw_run;
      if (mem_write && ir_write) overlap++;
      @(posedge clk);
      #1;
      if (state_o == 4'd1) seen_decode = 1'b1;
      if (state_o == 4'd0 && seen_decode) done = 1'b1;
    end
    check("sw_done", 32'(done), 32'd1);
    check("sw_mem_write_cycles", 32'(mw_cnt), 32'd3);
    check("sw_mem_write_consecutive", 32'(mw_max), 32'd3);
    check("sw_mem_write_ir_write_overlap", 32'(overlap), 32'd0);

    // Waiting disabled: mem_ready held low is ignored, lw still takes 5 cycles.
    do_reset();
    @(negedge clk);
    reset = 1'b0;
    op = LW;
    mem_ready = 1'b0;
    #1;
    check("nowait_fetch_pc_write", 32'(n_pc_write), 32'd1);
    check("nowait_fetch_ir_write", 32'(n_ir_write), 32'd1);
    check("wait_fetch_pc_write_stalled", 32'(pc_write), 32'd0);
    cycles = 1;
    seen_decode = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
      if (n_state_o == 4'd1) seen_decode = 1'b1;
      if (n_state_o == 4'd0 && seen_decode) done = 1'b1;
      else cycles++;
    end
    check("nowait_lw_done", 32'(done), 32'd1);
    check("nowait_lw_cycles", 32'(cycles), 32'd5);
    check("wait_still_in_fetch", 32'(state_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
